// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: consumer end of the radix-4 Booth partial-product stream.
// Each accepted PP (plus its negate bit) is sign-extended, shifted by 2*idx and
// summed; after NUM_PP products the sum is registered to 'product' and held on a
// valid/ready output until taken.
// Optional feature macro: BOOTH_ACC_PROTO_CHECK_EN (sticky pp_last mismatch flag).
module booth_pp_accumulator #(
  parameter int MCAND_W = 32,
  parameter int PP_W    = MCAND_W + 2,
  parameter int NUM_PP  = MCAND_W / 2 + 1,
  parameter int PROD_W  = 2 * MCAND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pp_valid,
  output logic              pp_ready,
  input  logic [PP_W-1:0]   pp_data,
  input  logic              pp_neg,
  input  logic              pp_last,
  output logic              prod_valid,
  input  logic              prod_ready,
  output logic [PROD_W-1:0] product,
  output logic              proto_err
);

  localparam int               IDX_W    = $clog2(NUM_PP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PP - 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [PROD_W-1:0]  acc, pp_ext, term, acc_sum;
  logic               pp_hs, prod_hs, at_last;

  assign pp_hs   = pp_valid & pp_ready;
  assign prod_hs = prod_valid & prod_ready;
  assign at_last = (idx == LAST_IDX);

  // Sign-extend first, add the negate correction, then weight by 4^idx;
  // anything carried past PROD_W is intentionally dropped.
  assign pp_ext  = {{(PROD_W-PP_W){pp_data[PP_W-1]}}, pp_data};
  assign term    = (pp_ext + PROD_W'(pp_neg)) << {idx, 1'b0};
  assign acc_sum = acc + term;

  // Next-state and handshake outputs; ready/valid come straight from state.
  always_comb begin
    state_nxt  = state;
    pp_ready   = 1'b0;
    prod_valid = 1'b0;
    case (state)
      ACCUM: begin
        pp_ready = 1'b1;
        if (pp_hs && at_last) state_nxt = DONE;
      end
      DONE: begin
        prod_valid = 1'b1;
        if (prod_hs) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Accumulator, PP index and the held product register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      idx     <= '0;
      product <= '0;
    end else if (pp_hs) begin
      acc <= acc_sum;
      if (at_last) begin
        idx     <= '0;
        product <= acc_sum;
      end else begin
        idx <= idx + 1'b1;
      end
    end else if (prod_hs) begin
      acc <= '0;
    end
  end

`ifdef BOOTH_ACC_PROTO_CHECK_EN
  // Sticky flag: producer's pp_last disagrees with our own PP counter.
  always_ff @(posedge clk) begin
    if (!rst_n)                             proto_err <= 1'b0;
    else if (pp_hs && (pp_last != at_last)) proto_err <= 1'b1;
  end
`else
  logic unused_pp_last;
  assign unused_pp_last = pp_last;
  assign proto_err      = 1'b0;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator: a table of multiplications whose
// products were worked out by hand, fed through a small radix-4 Booth producer
// model, plus hand sequences for back-pressure, mid-product reset and pp_last.
module tb_booth_pp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pp_valid, pp_ready, pp_neg, pp_last;
  logic [33:0] pp_data;
  logic        prod_valid, prod_ready, proto_err;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  booth_pp_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .pp_valid(pp_valid), .pp_ready(pp_ready), .pp_data(pp_data),
    .pp_neg(pp_neg), .pp_last(pp_last),
    .prod_valid(prod_valid), .prod_ready(prod_ready),
    .product(product), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[8];
  logic [33:0] pp_d[17];
  bit          pp_n[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Radix-4 Booth producer: multiplier extended to 34 bits with an implicit 0 below.
  task automatic gen_pps(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic [33:0] x, m;
    logic [34:0] ye;
    logic [2:0]  g;
    x  = sgn ? {{2{a[31]}}, a} : {2'b00, a};
    ye = sgn ? {b[31], b[31], b, 1'b0} : {2'b00, b, 1'b0};
    for (int i = 0; i < 17; i++) begin
      g = ye[2*i+2 -: 3];
      case (g)
        3'b001, 3'b010, 3'b101, 3'b110: m = x;
        3'b011, 3'b100:                 m = x << 1;
        default:                        m = '0;
      endcase
      pp_n[i] = g[2];
      pp_d[i] = g[2] ? ~m : m;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One PP handshake, bounded wait on pp_ready.
  task automatic send_pp(input logic [33:0] d, input bit n, input bit l);
    int t = 0;
    pp_valid = 1'b1; pp_data = d; pp_neg = n; pp_last = l;
    while (!pp_ready && t < 50) begin step(); t++; end
    if (!pp_ready) begin
      checks++; errors++;
      $display("FAIL pp_ready_timeout: got 0 expected 1");
    end
    step();
    pp_valid = 1'b0; pp_last = 1'b0;
  endtask

  // Send the 17 prepared PPs; last_at marks which index carries pp_last.
  task automatic send_all(input bit gaps, input int last_at);
    for (int i = 0; i < 17; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      send_pp(pp_d[i], pp_n[i], i == last_at);
    end
  endtask

  // After the final PP: prod_valid must already be up; check and retire it.
  task automatic take_product(input string name, input logic [63:0] exp);
    chk({name, "_valid_latency"}, {63'd0, prod_valid}, 64'd1);
    chk({name, "_product"}, product, exp);
    prod_ready = 1'b1;
    step();
    prod_ready = 1'b0;
    chk({name, "_ready_back"}, {63'd0, pp_ready}, 64'd1);
  endtask

  initial begin
    vecs[0] = '{32'd3,        32'd5,        1'b1, 64'h000000000000000F};
    vecs[1] = '{32'd3,        32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFD};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};
    vecs[5] = '{32'h00000000, 32'h12345678, 1'b1, 64'h0000000000000000};
    vecs[6] = '{32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000};
    vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};

    rst_n = 1'b0; pp_valid = 1'b0; pp_data = '0; pp_neg = 1'b0;
    pp_last = 1'b0; prod_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;

    chk("rst_pp_ready",   {63'd0, pp_ready},   64'd1);
    chk("rst_prod_valid", {63'd0, prod_valid}, 64'd0);
    chk("rst_product",    product,             64'd0);
    chk("rst_proto_err",  {63'd0, proto_err},  64'd0);

    // Table-driven products, no gaps.
    for (int v = 0; v < 8; v++) begin
      gen_pps(vecs[v].a, vecs[v].b, vecs[v].sgn);
      send_all(1'b0, 16);
      take_product($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Same unsigned all-ones product with random bubbles between PPs.
    gen_pps(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    send_all(1'b1, 16);
    take_product("gaps", 64'hFFFFFFFE00000001);

    // Back-pressure: hold prod_ready low with a stray PP offered meanwhile.
    gen_pps(32'd3, 32'd5, 1'b1);
    send_all(1'b0, 16);
    pp_valid = 1'b1; pp_data = 34'h155555555; pp_neg = 1'b1;
    begin
      int bad = 0;
      for (int c = 0; c < 10; c++) begin
        if (product !== 64'hF || prod_valid !== 1'b1 || pp_ready !== 1'b0) bad++;
        step();
      end
      chk("bp_hold_bad_cycles", 64'(bad), 64'd0);
    end
    pp_valid = 1'b0;
    take_product("bp", 64'hF);
    chk("bp_prod_valid_drop", {63'd0, prod_valid}, 64'd0);
    send_all(1'b0, 16);
    take_product("bp_next", 64'hF);

    // Reset in the middle of a product must discard the partial sum.
    gen_pps(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 7; i++) send_pp(pp_d[i], pp_n[i], 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_pp_ready",   {63'd0, pp_ready},   64'd1);
    chk("midrst_prod_valid", {63'd0, prod_valid}, 64'd0);
    chk("midrst_product",    product,             64'd0);
    gen_pps(32'd3, 32'd5, 1'b1);
    send_all(1'b0, 16);
    take_product("midrst", 64'hF);

    // pp_last on index 5 instead of 16.
    gen_pps(32'd3, 32'hFFFFFFFF, 1'b1);
    for (int i = 0; i < 5; i++) send_pp(pp_d[i], pp_n[i], 1'b0);
    chk("proto_before", {63'd0, proto_err}, 64'd0);
    send_pp(pp_d[5], pp_n[5], 1'b1);
`ifdef BOOTH_ACC_PROTO_CHECK_EN
    chk("proto_set", {63'd0, proto_err}, 64'd1);
`else
    chk("proto_tied", {63'd0, proto_err}, 64'd0);
`endif
    for (int i = 6; i < 17; i++) send_pp(pp_d[i], pp_n[i], 1'b0);
    take_product("proto", 64'hFFFFFFFFFFFFFFFD);
    gen_pps(32'd3, 32'd5, 1'b1);
    send_all(1'b0, 16);
    take_product("proto_next", 64'hF);
`ifdef BOOTH_ACC_PROTO_CHECK_EN
    chk("proto_sticky", {63'd0, proto_err}, 64'd1);
`else
    chk("proto_sticky_tied", {63'd0, proto_err}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
